// File: rtl/mavg_sched.sv
// mavg_sched: two-channel round-robin burst scheduler in front of a
// moving-average engine.
//
// Each grant runs IDLE -> CLEAR (1 cycle, engine cleared) -> STREAM (BURST
// cycles, samples pulled from the granted channel) -> DRAIN (LAT cycles while
// the engine pipeline empties) -> IDLE.
//
// Ports:
//   clk, RST             clock, synchronous active-high reset
//   req[1:0]             per-channel burst request
//   din0/din1            channel sample data
//   mask0/mask1          channel averaging mask (latched at grant)
//   take[1:0]            sample-consumed strobe for the granted channel
//   done[1:0]            one-cycle burst-complete pulse
//   busy                 FSM not in IDLE
//   eng_nrst, eng_e      engine active-low clear and enable
//   eng_data, eng_mask   engine sample and mask inputs
//   eng_dout, eng_eout   engine result and result-valid
//   dout, dvalid, dch    forwarded result, its valid, owning channel
module mavg_sched #(
  parameter int BURST = 8,
  parameter int LAT   = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic [9:0] din0,
  input  logic [9:0] din1,
  input  logic [9:0] mask0,
  input  logic [9:0] mask1,
  output logic [1:0] take,
  output logic [1:0] done,
  output logic       busy,
  output logic       eng_nrst,
  output logic       eng_e,
  output logic [9:0] eng_data,
  output logic [9:0] eng_mask,
  input  logic [9:0] eng_dout,
  input  logic       eng_eout,
  output logic [9:0] dout,
  output logic       dvalid,
  output logic       dch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [7:0] LAT_LAST   = 8'(LAT - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;    // shared by STREAM and DRAIN, restarted on each entry
  logic       last_reg;   // channel granted most recently
  logic       g_reg;      // channel currently granted
  logic [9:0] mask_reg;
  logic       grant_next;

  // Both requesting: the channel that did not go last wins. Otherwise the
  // single requester wins (req[1] selects channel 1).
  always_comb begin
    grant_next = req[1];
    if (req == 2'b11) grant_next = ~last_reg;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      g_reg     <= 1'b0;
      mask_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            g_reg     <= grant_next;
            mask_reg  <= grant_next ? mask1 : mask0;
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_reg   <= '0;
          state_reg <= STREAM;
        end
        STREAM: begin
          if (cnt_reg == BURST_LAST) begin
            cnt_reg   <= '0;
            state_reg <= DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt_reg == LAT_LAST) begin
            cnt_reg   <= '0;
            last_reg  <= g_reg;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-channel strobes, decoded from the registered state.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign take[gi] = (state_reg == STREAM) && (g_reg == 1'(gi));
      assign done[gi] = (state_reg == DRAIN) && (cnt_reg == LAT_LAST) &&
                        (g_reg == 1'(gi));
    end
  endgenerate

  assign busy     = (state_reg != IDLE);
  // Held low during reset as well, so the engine starts from a clean state.
  assign eng_nrst = (state_reg != CLEAR) && !RST;
  assign eng_e    = (state_reg == STREAM);
  assign eng_data = g_reg ? din1 : din0;
  assign eng_mask = mask_reg;
  assign dout     = eng_dout;
  assign dvalid   = eng_eout && ((state_reg == STREAM) || (state_reg == DRAIN));
  assign dch      = g_reg;

endmodule

// File: tb/tb_mavg_sched.sv
// Self-checking bench for mavg_sched: directed scenarios followed by random
// traffic, all checked every cycle against a burst-timeline reference model.
module tb_mavg_sched;
  localparam int BURST = 8;
  localparam int LAT   = 1;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = 2'b00;
  logic [9:0] din0 = '0, din1 = '0, mask0 = '0, mask1 = '0, eng_dout = '0;
  logic       eng_eout = 1'b0;
  logic [1:0] take, done;
  logic       busy, eng_nrst, eng_e, dvalid, dch;
  logic [9:0] eng_data, eng_mask, dout;

  mavg_sched #(.BURST(BURST), .LAT(LAT)) dut (
    .clk(clk), .RST(RST), .req(req), .din0(din0), .din1(din1),
    .mask0(mask0), .mask1(mask1), .take(take), .done(done), .busy(busy),
    .eng_nrst(eng_nrst), .eng_e(eng_e), .eng_data(eng_data),
    .eng_mask(eng_mask), .eng_dout(eng_dout), .eng_eout(eng_eout),
    .dout(dout), .dvalid(dvalid), .dch(dch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a burst is a timeline anchored at the cycle in which
  // IDLE accepted the request (start). Offset k = cyc - start gives:
  // 1 clear, 2..BURST+1 stream, BURST+2..BURST+LAT+1 drain.
  int         cyc = 0;
  int         start = -1;
  int         m_last = 1;
  int         m_g = 0;
  logic [9:0] m_mask = '0;

  // Scenario statistics gathered from DUT outputs.
  int  n_take0, n_done0, n_busy, n_clr;
  int  order[$];
  logic [1:0] prev_take = 2'b00;

  logic [9:0] seq [8] = '{10'd80, 10'd60, 10'd75, 10'd68, 10'd55, 10'd49, 10'd90, 10'd70};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int kval();
    return (start < 0) ? -1 : cyc - start;
  endfunction

  task automatic model_edge();
    if (RST) begin
      start  = -1;
      m_last = 1;
      m_g    = 0;
      m_mask = '0;
    end else if (start < 0) begin
      if (req != 2'b00) begin
        m_g    = (req == 2'b11) ? 1 - m_last : int'(req[1]);
        m_mask = (m_g == 1) ? mask1 : mask0;
        start  = cyc;
      end
    end else if (cyc - start == BURST + LAT + 1) begin
      m_last = m_g;
      start  = -1;
    end
    cyc++;
  endtask

  task automatic cycle();
    int k;
    logic clr, str, drn;
    logic [1:0] gb;
    @(negedge clk);
    k   = kval();
    clr = (k == 1);
    str = (k >= 2) && (k <= BURST + 1);
    drn = (k >= BURST + 2);
    gb  = (m_g == 1) ? 2'b10 : 2'b01;
    check("take",     32'(take),     32'(str ? gb : 2'b00));
    check("done",     32'(done),     32'((k == BURST + LAT + 1) ? gb : 2'b00));
    check("busy",     32'(busy),     32'(k >= 1));
    check("eng_nrst", 32'(eng_nrst), 32'(!RST && !clr));
    check("eng_e",    32'(eng_e),    32'(str));
    check("eng_data", 32'(eng_data), 32'((m_g == 1) ? din1 : din0));
    check("eng_mask", 32'(eng_mask), 32'(m_mask));
    check("dout",     32'(dout),     32'(eng_dout));
    check("dvalid",   32'(dvalid),   32'(eng_eout && (str || drn)));
    check("dch",      32'(dch),      32'(m_g));
    n_take0 += int'(take[0]);
    n_done0 += int'(done[0]);
    n_busy  += int'(busy);
    n_clr   += int'(!eng_nrst && !RST);
    if (take != 2'b00 && prev_take == 2'b00) order.push_back(int'(take[1]));
    prev_take = take;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_stats();
    n_take0 = 0; n_done0 = 0; n_busy = 0; n_clr = 0;
    order.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; req = 2'b00; eng_eout = 1'b0;
    cycle(); cycle();
    RST = 1'b0;
  endtask

  initial begin
    int k;
    @(posedge clk);
    model_edge();
    #1;
    do_reset();

    // Single burst with a fixed sample sequence; req[0] released after 3 takes.
    clear_stats();
    req = 2'b01; mask0 = 10'd10;
    for (int i = 0; i < 14; i++) begin
      k = kval();
      din0 = (k >= 2 && k <= BURST + 1) ? seq[k - 2] : 10'd0;
      if (k >= 5) req = 2'b00;
      cycle();
    end
    check("a_takes", 32'(n_take0), 32'(BURST));
    check("a_done",  32'(n_done0), 32'd1);
    check("a_busy",  32'(n_busy),  32'(1 + BURST + LAT));

    // Contention: three back-to-back grants ch0, ch1, ch0.
    do_reset();
    clear_stats();
    req = 2'b11;
    for (int i = 0; i < 3 * (BURST + LAT + 2); i++) cycle();
    req = 2'b00;
    cycle(); cycle();
    check("b_clears", 32'(n_clr), 32'd3);
    check("b_grants", 32'(order.size()), 32'd3);
    if (order.size() >= 3) begin
      check("b_order0", 32'(order[0]), 32'd0);
      check("b_order1", 32'(order[1]), 32'd1);
      check("b_order2", 32'(order[2]), 32'd0);
    end

    // Mask latch: mask1 changes mid-burst.
    do_reset();
    req = 2'b10; mask1 = 10'd10;
    for (int i = 0; i < 13; i++) begin
      k = kval();
      if (k >= 2) req = 2'b00;
      if (k == 4) mask1 = 10'd5;
      cycle();
    end

    // Reset after four takes; the next grant must go to channel 0.
    do_reset();
    clear_stats();
    req = 2'b11;
    for (int i = 0; i < 20 && kval() != 6; i++) cycle();
    check("d_reached", 32'(kval()), 32'd6);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check("d_done", 32'(n_done0), 32'd0);
    check("d_grants", 32'(order.size()), 32'd2);
    if (order.size() >= 2) check("d_regrant", 32'(order[1]), 32'd0);

    // Result forwarding during a channel-1 burst, then in IDLE.
    do_reset();
    req = 2'b10;
    eng_dout = 10'd10;
    for (int i = 0; i < 16; i++) begin
      k = kval();
      if (k >= 2) req = 2'b00;
      eng_eout = (k >= 3 && k <= 5) || (i >= 13);
      cycle();
    end
    eng_eout = 1'b0;

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      din0     = 10'($urandom);
      din1     = 10'($urandom);
      mask0    = 10'($urandom);
      mask1    = 10'($urandom);
      eng_dout = 10'($urandom);
      eng_eout = 1'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
